// File: rtl/conv_gemm_tile_sequencer.sv
// conv_gemm_tile_sequencer
//   Runtime-configurable tile scheduler for im2col convolution GEMMs,
//   C[MxN] = A[MxK] * B[KxN]. A layer config is accepted through a cfg
//   handshake. The GEMM is then walked in SA_N x SA_N x SA_N tiles with k
//   innermost, then n, then m. One command is issued per tile: element
//   addresses, clipped edge extents, and first-k/last-k accumulator flags.
//
// Handshakes (both channels): a transfer happens on a rising clk edge where
//   valid & ready are both high. cfg_ready is high only in IDLE. tile_valid,
//   once raised, stays high and every tile_* output holds stable until
//   tile_ready is seen.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   cfg_valid/cfg_ready       layer config handshake
//   cfg_m/k/n                 GEMM dimensions (a zero dimension is rejected with err)
//   cfg_a/b/c_base            row-major base element addresses
//   tile_valid/tile_ready     tile command handshake
//   tile_a/b/c_addr           tile origin addresses (wrap modulo 2^ADDR_W)
//   tile_rows/cols/depth      clipped extents, each in 1..SA_N
//   tile_first_k/last_k       clear accumulators / write back C tile
//   busy, done, err           status; done and err are one-cycle pulses
//   dbg_state                 current FSM state, for checkers
//   perf_stall_cycles         stall counter (only with PERF_CNT_EN)
//
// Optional feature: define PERF_CNT_EN to add perf_stall_cycles. This counts
//   cycles with tile_valid & !tile_ready and saturates at 2^32-1. It clears on
//   cfg acceptance and on rst.
module conv_gemm_tile_sequencer #(
  parameter int SA_N   = 64,
  parameter int M_W    = 16,
  parameter int K_W    = 12,
  parameter int N_W    = 10,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [M_W-1:0]           cfg_m,
  input  logic [K_W-1:0]           cfg_k,
  input  logic [N_W-1:0]           cfg_n,
  input  logic [ADDR_W-1:0]        cfg_a_base,
  input  logic [ADDR_W-1:0]        cfg_b_base,
  input  logic [ADDR_W-1:0]        cfg_c_base,
  output logic                     tile_valid,
  input  logic                     tile_ready,
  output logic [ADDR_W-1:0]        tile_a_addr,
  output logic [ADDR_W-1:0]        tile_b_addr,
  output logic [ADDR_W-1:0]        tile_c_addr,
  output logic [$clog2(SA_N):0]    tile_rows,
  output logic [$clog2(SA_N):0]    tile_cols,
  output logic [$clog2(SA_N):0]    tile_depth,
  output logic                     tile_first_k,
  output logic                     tile_last_k,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [1:0]               dbg_state
`ifdef PERF_CNT_EN
  , output logic [31:0]            perf_stall_cycles
`endif
);

  localparam int EXT_W = $clog2(SA_N) + 1;
  localparam logic [M_W-1:0]   SA_M   = M_W'(SA_N);
  localparam logic [N_W-1:0]   SA_NN  = N_W'(SA_N);
  localparam logic [K_W-1:0]   SA_K   = K_W'(SA_N);
  localparam logic [EXT_W-1:0] SA_EXT = EXT_W'(SA_N);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Captured layer config, immutable until the next acceptance in IDLE.
  logic [M_W-1:0]    m_q;
  logic [K_W-1:0]    k_q;
  logic [N_W-1:0]    n_q;
  logic [ADDR_W-1:0] a_base_q, b_base_q, c_base_q;

  // Origin of the tile currently presented on tile_*.
  logic [M_W-1:0] m0_q;
  logic [N_W-1:0] n0_q;
  logic [K_W-1:0] k0_q;

  logic accept, cfg_zero, start, fire;
  logic last_k, last_n, last_m, final_tile;

  // Next tile origin plus the config it is evaluated against. In IDLE the
  // source is the live cfg inputs, so tile0 is registered on acceptance.
  logic [M_W-1:0]    nm, src_m, rem_m;
  logic [N_W-1:0]    nn, src_n, rem_n;
  logic [K_W-1:0]    nk, src_k, rem_k;
  logic [ADDR_W-1:0] src_a, src_b, src_c;
  logic [ADDR_W-1:0] nxt_a, nxt_b, nxt_c;
  logic [EXT_W-1:0]  nxt_rows, nxt_cols, nxt_depth;
  logic              nxt_first, nxt_last;

  assign accept   = (state_q == S_IDLE) && cfg_valid;
  assign cfg_zero = (cfg_m == '0) || (cfg_k == '0) || (cfg_n == '0);
  assign start    = accept && !cfg_zero;
  assign fire     = tile_valid && tile_ready;

  assign last_k     = ({1'b0, k0_q} + {1'b0, SA_K})  >= {1'b0, k_q};
  assign last_n     = ({1'b0, n0_q} + {1'b0, SA_NN}) >= {1'b0, n_q};
  assign last_m     = ({1'b0, m0_q} + {1'b0, SA_M})  >= {1'b0, m_q};
  assign final_tile = (state_q == S_ISSUE) && last_k && last_n && last_m;

  always_comb begin
    nm    = m0_q;
    nn    = n0_q;
    nk    = k0_q;
    src_m = m_q;
    src_n = n_q;
    src_k = k_q;
    src_a = a_base_q;
    src_b = b_base_q;
    src_c = c_base_q;
    if (state_q == S_IDLE) begin
      nm    = '0;
      nn    = '0;
      nk    = '0;
      src_m = cfg_m;
      src_n = cfg_n;
      src_k = cfg_k;
      src_a = cfg_a_base;
      src_b = cfg_b_base;
      src_c = cfg_c_base;
    end else if (last_k) begin
      nk = '0;
      if (last_n) begin
        nn = '0;
        nm = last_m ? '0 : m0_q + SA_M;
      end else begin
        nn = n0_q + SA_NN;
      end
    end else begin
      nk = k0_q + SA_K;
    end

    rem_m     = src_m - nm;
    rem_n     = src_n - nn;
    rem_k     = src_k - nk;
    nxt_rows  = (rem_m >= SA_M)  ? SA_EXT : EXT_W'(rem_m);
    nxt_cols  = (rem_n >= SA_NN) ? SA_EXT : EXT_W'(rem_n);
    nxt_depth = (rem_k >= SA_K)  ? SA_EXT : EXT_W'(rem_k);
    nxt_first = (nk == '0);
    nxt_last  = ({1'b0, nk} + {1'b0, SA_K}) >= {1'b0, src_k};
    // Products are formed at ADDR_W and wrap silently.
    nxt_a = src_a + ADDR_W'(nm) * ADDR_W'(src_k) + ADDR_W'(nk);
    nxt_b = src_b + ADDR_W'(nk) * ADDR_W'(src_n) + ADDR_W'(nn);
    nxt_c = src_c + ADDR_W'(nm) * ADDR_W'(src_n) + ADDR_W'(nn);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ISSUE;
      S_ISSUE: if (fire && final_tile) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q          <= '0;
      k_q          <= '0;
      n_q          <= '0;
      a_base_q     <= '0;
      b_base_q     <= '0;
      c_base_q     <= '0;
      m0_q         <= '0;
      n0_q         <= '0;
      k0_q         <= '0;
      tile_valid   <= 1'b0;
      tile_a_addr  <= '0;
      tile_b_addr  <= '0;
      tile_c_addr  <= '0;
      tile_rows    <= '0;
      tile_cols    <= '0;
      tile_depth   <= '0;
      tile_first_k <= 1'b0;
      tile_last_k  <= 1'b0;
      err          <= 1'b0;
    end else begin
      err <= accept && cfg_zero;
      if (start) begin
        m_q      <= cfg_m;
        k_q      <= cfg_k;
        n_q      <= cfg_n;
        a_base_q <= cfg_a_base;
        b_base_q <= cfg_b_base;
        c_base_q <= cfg_c_base;
      end
      if (start || (fire && !final_tile)) begin
        m0_q         <= nm;
        n0_q         <= nn;
        k0_q         <= nk;
        tile_valid   <= 1'b1;
        tile_a_addr  <= nxt_a;
        tile_b_addr  <= nxt_b;
        tile_c_addr  <= nxt_c;
        tile_rows    <= nxt_rows;
        tile_cols    <= nxt_cols;
        tile_depth   <= nxt_depth;
        tile_first_k <= nxt_first;
        tile_last_k  <= nxt_last;
      end else if (fire && final_tile) begin
        tile_valid <= 1'b0;
      end
    end
  end

`ifdef PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || start) perf_stall_cycles <= '0;
    else if (tile_valid && !tile_ready && (perf_stall_cycles != 32'hFFFF_FFFF))
      perf_stall_cycles <= perf_stall_cycles + 32'd1;
  end
`endif

  assign cfg_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_conv_gemm_tile_sequencer.sv
module tb_conv_gemm_tile_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [15:0] cfg_m = '0;
  logic [11:0] cfg_k = '0;
  logic [9:0]  cfg_n = '0;
  logic [31:0] cfg_a_base = '0, cfg_b_base = '0, cfg_c_base = '0;
  logic        tile_valid;
  logic        tile_ready = 1'b0;
  logic [31:0] tile_a_addr, tile_b_addr, tile_c_addr;
  logic [6:0]  tile_rows, tile_cols, tile_depth;
  logic        tile_first_k, tile_last_k;
  logic        busy, done, err;
  logic [1:0]  dbg_state;
`ifdef PERF_CNT_EN
  logic [31:0] perf_stall_cycles;
`endif

  conv_gemm_tile_sequencer dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_n(cfg_n),
    .cfg_a_base(cfg_a_base), .cfg_b_base(cfg_b_base), .cfg_c_base(cfg_c_base),
    .tile_valid(tile_valid), .tile_ready(tile_ready),
    .tile_a_addr(tile_a_addr), .tile_b_addr(tile_b_addr), .tile_c_addr(tile_c_addr),
    .tile_rows(tile_rows), .tile_cols(tile_cols), .tile_depth(tile_depth),
    .tile_first_k(tile_first_k), .tile_last_k(tile_last_k),
    .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
`ifdef PERF_CNT_EN
    , .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [6:0]  r;
    logic [6:0]  cl;
    logic [6:0]  d;
    logic        f;
    logic        l;
  } tile_t;

  int    total = 0;
  int    bad   = 0;
  tile_t obs_log[16];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expire(input string tag, input int limit);
    total++;
    bad++;
    $error("FAIL %s bound of %0d cycles expired", tag, limit);
  endtask

  function automatic tile_t dut_tile();
    tile_t t;
    t = '{tile_a_addr, tile_b_addr, tile_c_addr, tile_rows, tile_cols,
          tile_depth, tile_first_k, tile_last_k};
    return t;
  endfunction

  // ---------------- driver + scoreboard for one layer ----------------
  // Reference: plain nested loops over tile origins, k innermost.
  task automatic run_layer(input int m, input int k, input int n,
                           input logic [31:0] ab, input logic [31:0] bb, input logic [31:0] cb,
                           input int rdy_pct, input int stop_after, output int hs);
    tile_t exp_q[$];
    tile_t cur, prev, e;
    int    stalls, cycles, budget;
    bit    have_prev, aborted;
    for (int mi = 0; mi < m; mi += 64)
      for (int ni = 0; ni < n; ni += 64)
        for (int ki = 0; ki < k; ki += 64) begin
          e.a  = ab + 32'(longint'(mi) * k + ki);
          e.b  = bb + 32'(longint'(ki) * n + ni);
          e.c  = cb + 32'(longint'(mi) * n + ni);
          e.r  = 7'((m - mi) < 64 ? (m - mi) : 64);
          e.cl = 7'((n - ni) < 64 ? (n - ni) : 64);
          e.d  = 7'((k - ki) < 64 ? (k - ki) : 64);
          e.f  = (ki == 0);
          e.l  = (ki + 64 >= k);
          exp_q.push_back(e);
        end
    budget = 20 * exp_q.size() + 100;

    @(negedge clk);
    cfg_m = 16'(m); cfg_k = 12'(k); cfg_n = 10'(n);
    cfg_a_base = ab; cfg_b_base = bb; cfg_c_base = cb;
    cfg_valid = 1'b1;
    chk("cfg_ready_offer", cfg_ready, 1);
    @(negedge clk);
    cfg_valid = 1'b0;
    // Junk on cfg while busy must be ignored.
    cfg_m = 16'($urandom_range(1, 65535)); cfg_k = 12'($urandom_range(1, 4095));
    cfg_n = 10'($urandom_range(1, 1023));
    cfg_a_base = $urandom; cfg_b_base = $urandom; cfg_c_base = $urandom;
    chk("busy_start", busy, 1);
    chk("cfg_ready_busy", cfg_ready, 0);

    hs = 0; stalls = 0; cycles = 0; have_prev = 0; aborted = 0;
    while (exp_q.size() > 0) begin
      if (cycles > budget) begin
        expire("tile_budget", budget);
        break;
      end
      chk("tile_valid", tile_valid, 1);
      if (tile_valid !== 1'b1) break;
      cur = dut_tile();
      if (have_prev) chk("stall_stable", cur, prev);
      tile_ready = ($urandom_range(99) < rdy_pct);
      if (tile_ready) begin
        e = exp_q.pop_front();
        chk("a_addr", cur.a, e.a);
        chk("b_addr", cur.b, e.b);
        chk("c_addr", cur.c, e.c);
        chk("rows", cur.r, e.r);
        chk("cols", cur.cl, e.cl);
        chk("depth", cur.d, e.d);
        chk("first_k", cur.f, e.f);
        chk("last_k", cur.l, e.l);
        if (hs < 16) obs_log[hs] = cur;
        hs++;
        have_prev = 0;
      end else begin
        stalls++;
        prev = cur;
        have_prev = 1;
      end
      @(negedge clk);
      cycles++;
      if (stop_after != 0 && hs == stop_after) begin
        aborted = 1;
        break;
      end
    end
    tile_ready = 1'b0;

    if (!aborted && exp_q.size() == 0) begin
      chk("done_pulse", done, 1);
      chk("valid_after_last", tile_valid, 0);
      chk("busy_in_done", busy, 1);
`ifdef PERF_CNT_EN
      chk("perf_stalls", perf_stall_cycles, stalls);
`endif
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("cfg_ready_idle", cfg_ready, 1);
      chk("busy_idle", busy, 0);
`ifdef PERF_CNT_EN
      chk("perf_hold", perf_stall_cycles, stalls);
`endif
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int hs;
    int c6[8];
    c6 = '{0, 0, 64, 64, 8192, 8192, 8256, 8256};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    // Reset state
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_tile_valid", tile_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_state", dbg_state, 0);
    chk("rst_tile_bus", {tile_a_addr, tile_b_addr, tile_c_addr, tile_rows,
                         tile_cols, tile_depth, tile_first_k, tile_last_k}, 0);
`ifdef PERF_CNT_EN
    chk("rst_perf", perf_stall_cycles, 0);
`endif

    // 1: reference layer, always ready
    run_layer(3136, 363, 96, 0, 0, 0, 100, 0, hs);
    chk("t1_count", hs, 588);
    chk("t1_tile0", obs_log[0], {32'd0, 32'd0, 32'd0, 7'd64, 7'd64, 7'd64, 1'b1, 1'b0});
    chk("t1_t5_a", obs_log[5].a, 320);
    chk("t1_t5_b", obs_log[5].b, 30720);
    chk("t1_t5_depth", obs_log[5].d, 43);
    chk("t1_t5_last", obs_log[5].l, 1);
    chk("t1_t6_b", obs_log[6].b, 64);
    chk("t1_t6_c", obs_log[6].c, 64);
    chk("t1_t6_cols", obs_log[6].cl, 32);

    // 2: same layer, random back-pressure
    run_layer(3136, 363, 96, 0, 0, 0, 50, 0, hs);
    chk("t2_count", hs, 588);

    // 3: minimal layer
    run_layer(1, 1, 1, 32'h100, 32'h200, 32'h300, 100, 0, hs);
    chk("t3_count", hs, 1);
    chk("t3_tile", obs_log[0], {32'h100, 32'h200, 32'h300, 7'd1, 7'd1, 7'd1, 1'b1, 1'b1});

    // 4: zero dimension rejected
    @(negedge clk);
    cfg_m = 16'd5; cfg_k = 12'd0; cfg_n = 10'd5; cfg_valid = 1'b1;
    chk("t4_cfg_ready0", cfg_ready, 1);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("t4_err", err, 1);
    chk("t4_valid1", tile_valid, 0);
    chk("t4_cfg_ready1", cfg_ready, 1);
    @(negedge clk);
    chk("t4_err_pulse", err, 0);
    chk("t4_valid2", tile_valid, 0);
    chk("t4_cfg_ready2", cfg_ready, 1);
    chk("t4_busy", busy, 0);

    // 5: reset mid-layer, then restart
    run_layer(3136, 363, 96, 0, 0, 0, 100, 10, hs);
    chk("t5_hs", hs, 10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_valid", tile_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_cfg_ready", cfg_ready, 1);
    chk("t5_done", done, 0);
    @(negedge clk);
    chk("t5_no_done", done, 0);
    run_layer(3136, 363, 96, 0, 0, 0, 100, 0, hs);
    chk("t5_restart_tile0", obs_log[0], {32'd0, 32'd0, 32'd0, 7'd64, 7'd64, 7'd64, 1'b1, 1'b0});

    // 6: exact multiples
    run_layer(128, 128, 128, 0, 0, 0, 100, 0, hs);
    chk("t6_count", hs, 8);
    for (int i = 0; i < 8; i++) begin
      chk("t6_c_seq", obs_log[i].c, c6[i]);
      chk("t6_last_alt", obs_log[i].l, i % 2);
      chk("t6_full", {obs_log[i].r, obs_log[i].cl, obs_log[i].d}, {7'd64, 7'd64, 7'd64});
    end

    // Random layers with random bases (address wrap) and back-pressure
    for (int r = 0; r < 4; r++)
      run_layer($urandom_range(1, 300), $urandom_range(1, 200), $urandom_range(1, 200),
                $urandom, $urandom, $urandom, 60, 0, hs);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
